// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: start/data/[parity]/stop framing, one-cycle o_valid per frame.
// Define UART_RX_MAJORITY_EN for a 3-sample majority vote (ticks 7/8/9) instead of a tick-8 sample.
`timescale 1ns/1ps
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_baud_x16,
    output logic                  o_baud_x16_en,
    input  logic                  i_RX,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_frame_err,
    output logic                  o_parity_err,
    output logic                  o_busy
);
    localparam int IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    state_t                r_state;
    logic                  r_rx_meta, r_rx_s, r_rx_d;
    logic [3:0]            r_tick;
    logic [IdxW-1:0]       r_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_bad;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid, r_frame_err, r_parity_err, r_en;

    logic       w_fall, w_sample, w_sample_pt, w_bit_end;
    logic [4:0] w_tick_n;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_d    <= 1'b1;
        end else begin
            r_rx_meta <= i_RX;
            r_rx_s    <= r_rx_meta;
            r_rx_d    <= r_rx_s;
        end
    end

    assign w_fall    = r_rx_d & ~r_rx_s;
    // Number of the tick arriving this cycle within the current bit (1..16).
    assign w_tick_n  = {1'b0, r_tick} + 5'd1;
    assign w_bit_end = i_baud_x16 && (w_tick_n == 5'd16);

`ifdef UART_RX_MAJORITY_EN
    logic r_v7, r_v8;
    assign w_sample_pt = i_baud_x16 && (w_tick_n == 5'd9);
    assign w_sample    = (r_v7 & r_v8) | (r_v7 & r_rx_s) | (r_v8 & r_rx_s);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_v7 <= 1'b1;
            r_v8 <= 1'b1;
        end else if (i_baud_x16) begin
            if (w_tick_n == 5'd7) r_v7 <= r_rx_s;
            if (w_tick_n == 5'd8) r_v8 <= r_rx_s;
        end
    end
`else
    assign w_sample_pt = i_baud_x16 && (w_tick_n == 5'd8);
    assign w_sample    = r_rx_s;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_tick       <= 4'd0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_par_bad    <= 1'b0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_en         <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            // Follows the state one cycle late so the enable drops after the return to IDLE.
            r_en    <= (r_state != ST_IDLE);
            if (i_baud_x16) r_tick <= r_tick + 4'd1;
            unique case (r_state)
                ST_IDLE: begin
                    r_tick <= 4'd0;
                    if (w_fall) begin
                        r_state   <= ST_START;
                        r_idx     <= '0;
                        r_par_bad <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_sample_pt && w_sample) begin
                        r_state <= ST_IDLE;
                        r_tick  <= 4'd0;
                    end else if (w_bit_end) begin
                        r_state <= ST_DATA;
                        r_tick  <= 4'd0;
                    end
                end
                ST_DATA: begin
                    if (w_sample_pt) r_shift[r_idx] <= w_sample;
                    if (w_bit_end) begin
                        r_tick <= 4'd0;
                        if (r_idx == LastIdx) begin
                            r_state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_idx <= r_idx + IdxW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_sample_pt) r_par_bad <= w_sample ^ (^r_shift);
                    if (w_bit_end) begin
                        r_state <= ST_STOP;
                        r_tick  <= 4'd0;
                    end
                end
                ST_STOP: begin
                    // Leave mid-stop-bit so the next start edge is caught with half a bit of margin.
                    if (w_sample_pt) begin
                        r_data       <= r_shift;
                        r_frame_err  <= ~w_sample;
                        r_parity_err <= r_par_bad;
                        r_valid      <= 1'b1;
                        r_state      <= ST_IDLE;
                        r_tick       <= 4'd0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_data        = r_data;
    assign o_valid       = r_valid;
    assign o_frame_err   = r_frame_err;
    assign o_parity_err  = r_parity_err;
    assign o_baud_x16_en = r_en;
    assign o_busy        = (r_state != ST_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a no-parity and an even-parity instance, each fed by its own gated x16 divider.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int Half   = 20;   // 25 MHz
    localparam int BitCyc = 217;  // 115200 baud
    localparam int DivMax = 12;   // x16 tick every 13 cycles
`ifdef UART_RX_MAJORITY_EN
    localparam bit MajEn = 1'b1;
`else
    localparam bit MajEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx    [2];
    logic       en    [2];
    logic       tick  [2] = '{1'b0, 1'b0};
    logic       valid [2];
    logic       ferr  [2];
    logic       perr  [2];
    logic       busy  [2];
    logic [7:0] data  [2];
    int         div   [2] = '{0, 0};

    int         checks = 0;
    int         errors = 0;
    int         pulses [2] = '{0, 0};
    logic [7:0] cap_data [2];
    logic       cap_ferr [2];
    logic       cap_perr [2];
    logic       prev_valid [2] = '{1'b0, 1'b0};
    logic [7:0] prev_data  [2];
    int         wide  = 0;
    int         stray = 0;

    always #Half clk = ~clk;

    uart_rx #(.DATA_WIDTH(8), .PARITY_EN(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_baud_x16(tick[0]), .o_baud_x16_en(en[0]), .i_RX(rx[0]),
        .o_data(data[0]), .o_valid(valid[0]), .o_frame_err(ferr[0]), .o_parity_err(perr[0]),
        .o_busy(busy[0])
    );

    uart_rx #(.DATA_WIDTH(8), .PARITY_EN(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_baud_x16(tick[1]), .o_baud_x16_en(en[1]), .i_RX(rx[1]),
        .o_data(data[1]), .o_valid(valid[1]), .o_frame_err(ferr[1]), .o_parity_err(perr[1]),
        .o_busy(busy[1])
    );

    // Divider restarts whenever its receiver drops the enable.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (en[k] !== 1'b1) begin
                div[k]  <= 0;
                tick[k] <= 1'b0;
            end else begin
                tick[k] <= (div[k] == DivMax);
                div[k]  <= (div[k] == DivMax) ? 0 : div[k] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (valid[k] === 1'b1) begin
                pulses[k]   <= pulses[k] + 1;
                cap_data[k] <= data[k];
                cap_ferr[k] <= ferr[k];
                cap_perr[k] <= perr[k];
                if (prev_valid[k] === 1'b1) wide <= wide + 1;
            end else if (!rst && data[k] !== prev_data[k]) begin
                stray <= stray + 1;
            end
            prev_valid[k] <= valid[k];
            prev_data[k]  <= data[k];
        end
    end

    initial begin
        #4_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one frame bit-by-bit; optional one-tick glitch centred on tick 56 (data bit 2 sample)
    // and optional reset mid-bit abort_bit.
    task automatic send(input int sel, input logic [7:0] b, input bit stop_lvl, input bit par_lvl,
                        input bit glitch, input int abort_bit);
        bit lv [12];
        int nb;
        int ne   = 0;
        int tcnt = 0;
        int g    = -100;
        lv[0] = 1'b0;
        for (int i = 0; i < 8; i++) lv[i+1] = b[i];
        nb = 9;
        if (sel == 1) begin
            lv[nb] = par_lvl;
            nb++;
        end
        lv[nb] = stop_lvl;
        nb++;
        for (int i = 0; i < nb; i++) begin
            for (int c = 0; c < BitCyc; c++) begin
                @(negedge clk);
                ne++;
                if (tick[sel] === 1'b1) begin
                    tcnt++;
                    if (glitch && tcnt == 55) g = ne + 5;
                end
                if (abort_bit == i && c == BitCyc / 2) begin
                    rst = 1'b1;
                    #1;
                    chk("rst_busy", 32'(busy[sel]), 0);
                    chk("rst_en", 32'(en[sel]), 0);
                    repeat (3) @(negedge clk);
                    rst     = 1'b0;
                    rx[sel] = 1'b1;
                    repeat (300) @(negedge clk);
                    return;
                end
                rx[sel] = lv[i] ^ (ne >= g && ne <= g + 12);
            end
        end
        rx[sel] = 1'b1;
        repeat (260) @(negedge clk);
    endtask

    task automatic frame(input int sel, input logic [7:0] b, input bit stop_lvl,
                         input bit par_lvl, input bit glitch, input string tag);
        int         p0 = pulses[sel];
        logic [7:0] exp_d;
        bit         exp_pe;
        send(sel, b, stop_lvl, par_lvl, glitch, -1);
        exp_d = b;
        if (glitch && !MajEn) exp_d = b ^ 8'h04;
        exp_pe = (sel == 1) && (par_lvl != ^b);
        chk({tag, "_pulses"}, 32'(pulses[sel]), 32'(p0 + 1));
        chk({tag, "_data"}, 32'(cap_data[sel]), 32'(exp_d));
        chk({tag, "_ferr"}, 32'(cap_ferr[sel]), 32'(!stop_lvl));
        chk({tag, "_perr"}, 32'(cap_perr[sel]), 32'(exp_pe));
        chk({tag, "_busy"}, 32'(busy[sel]), 0);
        chk({tag, "_en"}, 32'(en[sel]), 0);
    endtask

    initial begin
        int         p0;
        int         sel;
        logic [7:0] b;
        bit         stop_lvl;
        bit         par_lvl;
        rx[0] = 1'b1;
        rx[1] = 1'b1;
        #1 rst = 1'b1;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_data", 32'(data[k]), 0);
            chk("reset_valid", 32'(valid[k]), 0);
            chk("reset_ferr", 32'(ferr[k]), 0);
            chk("reset_perr", 32'(perr[k]), 0);
            chk("reset_busy", 32'(busy[k]), 0);
            chk("reset_en", 32'(en[k]), 0);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);

        frame(0, 8'hA6, 1'b1, 1'b0, 1'b0, "t1_a6");
        frame(0, 8'h37, 1'b1, 1'b0, 1'b0, "t1_37");
        frame(0, 8'h00, 1'b1, 1'b0, 1'b0, "t1_00");
        frame(0, 8'hFF, 1'b1, 1'b0, 1'b0, "t1_ff");

        p0    = pulses[0];
        rx[0] = 1'b0;
        repeat (39) @(negedge clk);
        chk("t2_busy_in", 32'(busy[0]), 1);
        rx[0] = 1'b1;
        repeat (300) @(negedge clk);
        chk("t2_pulses", 32'(pulses[0]), 32'(p0));
        chk("t2_busy", 32'(busy[0]), 0);
        chk("t2_en", 32'(en[0]), 0);

        frame(0, 8'h55, 1'b0, 1'b0, 1'b0, "t3_55");
        frame(0, 8'h12, 1'b1, 1'b0, 1'b0, "t3_12");

        frame(1, 8'h37, 1'b1, 1'b1, 1'b0, "t4_par1");
        frame(1, 8'h37, 1'b1, 1'b0, 1'b0, "t4_par0");

        p0 = pulses[0];
        send(0, 8'hC3, 1'b1, 1'b0, 1'b0, 5);
        chk("t5_no_pulse", 32'(pulses[0]), 32'(p0));
        frame(0, 8'h81, 1'b1, 1'b0, 1'b0, "t5_81");

        frame(0, 8'hF0, 1'b1, 1'b0, 1'b1, "t6_glitch");

        for (int n = 0; n < 6; n++) begin
            sel      = int'($urandom_range(0, 1));
            b        = 8'($urandom);
            stop_lvl = ($urandom_range(0, 3) != 0);
            par_lvl  = 1'($urandom_range(0, 1));
            frame(sel, b, stop_lvl, par_lvl, 1'b0, $sformatf("rnd%0d", n));
        end

        chk("valid_width", 32'(wide), 0);
        chk("data_hold", 32'(stray), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the UART: a 16x-oversampling deserialiser that recovers framed bytes from the serial line driven by `uart_tx` (or an external device). It sits downstream of the TX line and beside `uart_baudgen`, consuming that block's x16 tick and gating it with `o_baud_x16_en`. Each frame is presented as a one-cycle `o_valid` pulse with data and error flags.

## Interface
- `DATA_WIDTH`, 8: data bits per frame, sent LSB first.
- `PARITY_EN`, 0: 1 inserts an even-parity bit between the last data bit and the stop bit.

- `i_clk` in 1: system clock.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_baud_x16` in 1: one-cycle tick at 16x baud from `uart_baudgen.o_baud_x16`.
- `o_baud_x16_en` out 1: enable to `uart_baudgen.i_baud_x16_en`; high while a frame is in progress.
- `i_RX` in 1: asynchronous serial input; idles high.
- `o_data` out DATA_WIDTH: last received data; held until the next `o_valid`.
- `o_valid` out 1: one-cycle pulse when a frame completes.
- `o_frame_err` out 1: stop bit sampled low. Valid with `o_valid`.
- `o_parity_err` out 1: parity mismatch. Valid with `o_valid`. Always 0 when `PARITY_EN`=0.
- `o_busy` out 1: high whenever the state is not IDLE.

## Operation
- `i_RX` passes through a 2-flop synchroniser (reset to 1), then one more register for falling-edge detection. All logic uses the synchronised value `rx_s`.
- States: IDLE, START, DATA, PARITY, STOP.
- Each non-IDLE state uses a 4-bit tick counter. The counter advances only on `i_baud_x16` and holds values 1..16 within a bit. It clears on every state entry.
- Sample point: tick 8. With `UART_RX_MAJORITY_EN`, the sample is the majority of the values at ticks 7, 8 and 9, and is evaluated at tick 9.
- Transitions:
  - IDLE -> START on a falling edge of `rx_s`.
  - START: if the sample is 1, this is a false start; return to IDLE at the sample point. Otherwise move to DATA at tick 16.
  - DATA: shift the sample into bit `idx` (0..DATA_WIDTH-1) at the sample point. At tick 16, increment `idx`. After the last bit, go to PARITY if `PARITY_EN`, else STOP.
  - PARITY: at the sample point, compare the sample with the XOR of the data bits (even parity). Go to STOP at tick 16.
  - STOP: at the sample point, update `o_data`, set `o_frame_err` = !sample, set `o_parity_err`, pulse `o_valid`, and go straight to IDLE. Leaving mid-stop-bit gives half a bit of resync margin.
- `o_baud_x16_en` is registered. It is high from the cycle after the IDLE->START transition until the cycle after the return to IDLE.
- There is no downstream backpressure. A consumer that misses `o_valid` loses the byte.
- `i_RX` held low after a frame does not retrigger: a new falling edge is required.

## Timing
- Reset values: `o_data`=0, `o_valid`=0, `o_frame_err`=0, `o_parity_err`=0, `o_busy`=0, `o_baud_x16_en`=0. State is IDLE and the synchroniser holds 1.
- Edge detection latency: 3 `i_clk` cycles from the `i_RX` edge to START.
- `o_valid` pulses in the same cycle as the STOP sample tick plus one register stage. It is exactly one cycle wide.
- Error flags and `o_data` change only in the `o_valid` cycle.
- Reset asserted mid-frame: return to IDLE immediately. No `o_valid` is generated and `o_baud_x16_en` drops asynchronously.
- If `i_baud_x16` is asserted in the same cycle as a state entry, that tick counts as tick 1 of the new state.

## Configuration
- `UART_RX_MAJORITY_EN` defined: 3-sample majority vote at ticks 7, 8 and 9, with decisions made at tick 9. A single-tick glitch at the mid-bit point is rejected.
- `UART_RX_MAJORITY_EN` not defined: single sample at tick 8. No vote registers are present.

## Test plan
All scenarios use a 25 MHz clock and a bench divider producing `i_baud_x16` every 13 cycles, with `i_RX` driven at 115200 baud.
1. Send 0xA6, 0x37, 0x00 and 0xFF in turn → each gives one `o_valid` pulse with matching `o_data`, both error flags 0, and `o_busy` low after each.
2. Low pulse of 3 x16 ticks on idle `i_RX` → no `o_valid`; the block returns to IDLE and `o_baud_x16_en` deasserts.
3. Send 0x55 with the stop bit driven 0 → `o_valid`=1, `o_data`=0x55, `o_frame_err`=1. The next good frame of 0x12 gives `o_frame_err`=0.
4. With `PARITY_EN`=1, send 0x37 with parity bit 1 (correct) → `o_parity_err`=0. Then send 0x37 with parity bit 0 → `o_parity_err`=1.
5. Assert `i_rst` during data bit 4 of 0xC3, release it, then send 0x81 → no pulse for 0xC3; `o_data`=0x81 with a clean receive.
6. With `UART_RX_MAJORITY_EN`, invert `i_RX` for one tick period centred on the mid-point of data bit 2 of 0xF0 → `o_data`=0xF0. Without the macro, the same stimulus gives 0xF4.
